pll_clken_gen: RTL and testbench

PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

---
 rtl/pll_clken_gen_pkg.sv | 16 +
 rtl/pll_clken_gen_clken_divider.sv | 41 ++++
 rtl/pll_clken_gen.sv | 131 +++++++++++++
 tb/tb_pll_clken_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pll_clken_gen_pkg.sv
// Shared definitions for the PLL-gated clock-enable generator:
// lock FSM encoding and the settle-counter width helper.
package pll_clken_gen_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLING = 2'd1,
    RUN      = 2'd2
  } pll_state_e;

  // Counter must be able to hold SETTLE_CYCLES itself, hence the +1.
  function automatic int settle_width(input int settle_cycles);
    return $clog2(settle_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_clken_gen_clken_divider.sv
// Single clock-enable channel: counts up to a shadowed divisor and pulses
// on the wrap; the shadow reloads only at a wrap so periods are never cut.
module clken_divider
  import pll_clken_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 clk_en
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] shd_r;
  logic                 wrap_s;

  assign wrap_s = (cnt_r == shd_r);
  assign clk_en = enable && wrap_s;

  // Counter and shadow divisor; both hold while neither loading nor enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
      shd_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
      shd_r <= div;
    end else if (enable) begin
      if (wrap_s) begin
        cnt_r <= '0;
        shd_r <= div;
      end else begin
        cnt_r <= cnt_r + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pll_clken_gen.sv
// Lock qualification FSM (sync, settle, run) driving CHANNELS phase-aligned
// clock-enable dividers, plus a sticky lost-lock flag.
module pll_clken_gen
  import pll_clken_gen_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int DIV_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pll_locked,
  input  logic [CHANNELS*DIV_WIDTH-1:0] div_in,
  input  logic                          clear_lost,
  output logic                          ready,
  output logic [CHANNELS-1:0]           clk_en,
  output logic                          lock_lost,
  output logic [1:0]                    state
);

  localparam int            SW          = settle_width(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic          sync_meta_r;
  logic          sync_locked_r;
  pll_state_e    state_r;
  pll_state_e    state_next_s;
  logic [SW-1:0] settle_cnt_r;
  logic [SW-1:0] settle_cnt_next_s;
  logic          ready_r;
  logic          lock_lost_r;
  logic          run_s;
  logic          load_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta_r   <= 1'b0;
      sync_locked_r <= 1'b0;
    end else begin
      sync_meta_r   <= pll_locked;
      sync_locked_r <= sync_meta_r;
    end
  end

  // FSM state and settle counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= UNLOCKED;
      settle_cnt_r <= '0;
    end else begin
      state_r      <= state_next_s;
      settle_cnt_r <= settle_cnt_next_s;
    end
  end

  // Next-state logic; any loss of synchronised lock falls back to UNLOCKED.
  always_comb begin
    state_next_s      = state_r;
    settle_cnt_next_s = settle_cnt_r;
    case (state_r)
      UNLOCKED: begin
        if (sync_locked_r) begin
          state_next_s      = SETTLING;
          settle_cnt_next_s = '0;
        end else begin
          state_next_s = UNLOCKED;
        end
      end
      SETTLING: begin
        if (!sync_locked_r) begin
          state_next_s = UNLOCKED;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_next_s = RUN;
        end else begin
          settle_cnt_next_s = settle_cnt_r + SW'(1);
        end
      end
      RUN: begin
        if (!sync_locked_r) begin
          state_next_s = UNLOCKED;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = UNLOCKED;
      end
    endcase
  end

  // ready tracks the next state so it is high in exactly the RUN cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_r <= 1'b0;
    end else begin
      ready_r <= (state_next_s == RUN);
    end
  end

  // Sticky lost-lock flag; setting takes priority over clearing.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_lost_r <= 1'b0;
    end else if ((state_r == RUN) && (state_next_s == UNLOCKED)) begin
      lock_lost_r <= 1'b1;
    end else if (clear_lost) begin
      lock_lost_r <= 1'b0;
    end
  end

  assign run_s     = (state_r == RUN);
  assign load_s    = (state_r != RUN) && (state_next_s == RUN);
  assign ready     = ready_r;
  assign lock_lost = lock_lost_r;
  assign state     = state_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clken_divider #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_div (
      .clock  (clock),
      .reset  (reset),
      .load   (load_s),
      .enable (run_s),
      .div    (div_in[i*DIV_WIDTH +: DIV_WIDTH]),
      .clk_en (clk_en[i])
    );
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Self-checking bench: directed and random lock/divider stimulus compared
// every cycle against a lock-streak / pulse-schedule reference model.
module tb_pll_clken_gen;

  localparam int CH = 4;
  localparam int DW = 4;
  localparam int SC = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             pll_locked;
  logic [CH*DW-1:0] div_in;
  logic             clear_lost;
  logic             ready;
  logic [CH-1:0]    clk_en;
  logic             lock_lost;
  logic [1:0]       state;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: lock is qualified once the synchronised lock has been high for
  // SC+1 consecutive samples; each channel keeps the RUN-cycle index of its
  // next scheduled pulse.
  int   s1m, s2m, streak, rc;
  logic m_run, m_lost;
  int   nxt[CH];

  pll_clken_gen #(
    .CHANNELS(CH), .DIV_WIDTH(DW), .SETTLE_CYCLES(SC)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .div_in(div_in),
    .clear_lost(clear_lost), .ready(ready), .clk_en(clk_en),
    .lock_lost(lock_lost), .state(state)
  );

  always #5 clock = ~clock;

  function automatic int get_div(input int i);
    logic [DW-1:0] v;
    v = div_in[i*DW +: DW];
    return int'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int   seen;
    logic was_run;
    if (reset) begin
      s1m = 0; s2m = 0; streak = 0; rc = 0;
      m_run = 1'b0; m_lost = 1'b0;
    end else begin
      seen = s2m;
      s2m  = s1m;
      s1m  = int'(pll_locked);
      was_run = m_run;
      if (was_run)
        for (int i = 0; i < CH; i++)
          if (rc == nxt[i]) nxt[i] = rc + get_div(i) + 1;
      streak = (seen != 0) ? streak + 1 : 0;
      m_run  = (streak >= SC + 1);
      if (was_run && !m_run) m_lost = 1'b1;
      else if (clear_lost)   m_lost = 1'b0;
      if (m_run && !was_run) begin
        rc = 0;
        for (int i = 0; i < CH; i++) nxt[i] = get_div(i);
      end else if (m_run) begin
        rc = rc + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [CH-1:0] exp_en;
    logic [1:0]    exp_state;
    for (int i = 0; i < CH; i++) exp_en[i] = m_run && (rc == nxt[i]);
    exp_state = (streak == 0) ? 2'd0 : (m_run ? 2'd2 : 2'd1);
    chk("ready", 32'(ready), 32'(m_run));
    chk("state", 32'(state), 32'(exp_state));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("clk_en", 32'(clk_en), 32'(exp_en));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  initial begin : stim
    int   k;
    logic found;
    reset = 1'b1; pll_locked = 1'b0; clear_lost = 1'b0; div_in = '0;
    s1m = 0; s2m = 0; streak = 0; rc = 0; m_run = 1'b0; m_lost = 1'b0;
    for (int i = 0; i < CH; i++) nxt[i] = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Lock acquisition latency: sync (2) + UNLOCKED->SETTLING (1) + settle (SC).
    div_in = {4'd3, 4'd2, 4'd1, 4'd0};
    pll_locked = 1'b1;
    found = 1'b0; k = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      cycle();
      if (ready === 1'b1) begin found = 1'b1; k = i; end
    end
    chk("settle_latency", 32'(k), 32'(2 + 1 + SC));
    for (int i = 0; i < 24; i++) cycle();

    // Random divider changes while running.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) div_in = (CH*DW)'($urandom);
      cycle();
    end

    // Maximum divide value on channel 0.
    div_in = {4'd0, 4'd1, 4'd2, 4'd15};
    for (int i = 0; i < 50; i++) cycle();

    // Divider change mid-period: new value only after the next wrap.
    div_in = {4'd3, 4'd2, 4'd1, 4'd4};
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (clk_en[0] === 1'b1) found = 1'b1;
    end
    chk("ch0_pulse_seen", 32'(found), 32'd1);
    cycle(); cycle();
    div_in = {4'd3, 4'd2, 4'd1, 4'd1};
    for (int i = 0; i < 14; i++) cycle();

    // Lose lock in RUN with clear_lost coinciding with the set edge.
    pll_locked = 1'b0;
    cycle(); cycle();
    clear_lost = 1'b1;
    cycle();
    chk("lost_set_wins", 32'(lock_lost), 32'd1);
    clear_lost = 1'b0;
    cycle();
    clear_lost = 1'b1;
    cycle();
    chk("lost_cleared", 32'(lock_lost), 32'd0);
    clear_lost = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // One-cycle lock drop during SETTLING, then full resettle.
    pll_locked = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    pll_locked = 1'b0;
    cycle();
    pll_locked = 1'b1;
    for (int i = 0; i < 25; i++) cycle();
    chk("resettled_run", 32'(ready), 32'd1);

    // Reset mid-RUN with every channel pulsing each cycle.
    div_in = '0;
    for (int i = 0; i < 4; i++) cycle();
    reset = 1'b1;
    cycle();
    chk("reset_clk_en", 32'(clk_en), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) cycle();

    // Random lock flicker, clears and divider changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) pll_locked = ~pll_locked;
      clear_lost = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) div_in = (CH*DW)'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
